// File: rtl/alu_arithmetic.sv
// -----------------------------------------------------------------------------
// alu_arithmetic
//   Small registered arithmetic unit. The operands are narrowed to their low
//   OP_W bits. The unit can add, subtract, increment or clear. The result and
//   its overflow flag are captured together on every rising clock edge, so the
//   latency is exactly one cycle.
//
// Ports
//   CLK       in   1  rising-edge clock for all state
//   RST_N     in   1  asynchronous active-low reset; clears OUT/OVERFLOW at once
//   A         in   8  operand A, only A[OP_W-1:0] is used
//   B         in   8  operand B, only B[OP_W-1:0] is used
//   S         in   8  operation select, all 8 bits decoded:
//                     0 add, 1 subtract, 2 increment, anything else clear
//   OUT       out  8  registered result
//   OVERFLOW  out  1  registered overflow flag matching OUT
//
// Parameters
//   OP_W      operand field width in bits, legal range 1..7
// -----------------------------------------------------------------------------
module alu_arithmetic #(
  parameter int OP_W = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [7:0] S,
  output logic [7:0] OUT,
  output logic       OVERFLOW
);

  // Largest value an OP_W-bit operand can hold. It also serves as the mask.
  localparam logic [7:0] OP_MAX = 8'((1 << OP_W) - 1);

  localparam logic [7:0] SEL_ADD = 8'd0;
  localparam logic [7:0] SEL_SUB = 8'd1;
  localparam logic [7:0] SEL_INC = 8'd2;

  logic [7:0] a_op;
  logic [7:0] b_op;
  logic [7:0] out_d;
  logic [7:0] out_q;
  logic       ovf_d;
  logic       ovf_q;

  // Zero-extend the low OP_W bits. Upper operand bits never reach the result.
  function automatic logic [7:0] narrow_op(input logic [7:0] v);
    return v & OP_MAX;
  endfunction

  // With OP_W <= 7, a + b is at most 254. The 8-bit sum therefore never wraps.
  // Overflow is relative to the OP_W-bit field, not to the 8-bit output.
  function automatic logic [8:0] add_op(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] sum;
    sum = x + y;
    return {(sum > OP_MAX), sum};
  endfunction

  // Subtraction wraps modulo 256 and never reports overflow.
  function automatic logic [8:0] sub_op(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] diff;
    diff = x - y;
    return {1'b0, diff};
  endfunction

  // Increment is untruncated. It flags the step past the OP_W-bit maximum.
  function automatic logic [8:0] inc_op(input logic [7:0] x);
    logic [7:0] nxt;
    nxt = x + 8'd1;
    return {(x == OP_MAX), nxt};
  endfunction

  always_comb begin
    a_op  = narrow_op(A);
    b_op  = narrow_op(B);
    out_d = 8'd0;
    ovf_d = 1'b0;
    unique case (S)
      SEL_ADD: {ovf_d, out_d} = add_op(a_op, b_op);
      SEL_SUB: {ovf_d, out_d} = sub_op(a_op, b_op);
      SEL_INC: {ovf_d, out_d} = inc_op(a_op);
      // Clear, and every undefined select, leave the zero defaults.
      default: begin
        out_d = 8'd0;
        ovf_d = 1'b0;
      end
    endcase
  end

  // Result register stage. OUT and OVERFLOW share one flop group.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q <= 8'd0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign OUT      = out_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_alu_arithmetic.sv
module tb_alu_arithmetic;

  localparam int OP_W = 3;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic [7:0] A = 8'd0;
  logic [7:0] B = 8'd0;
  logic [7:0] S = 8'd3;
  logic [7:0] OUT;
  logic       OVERFLOW;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q[$];

  alu_arithmetic #(.OP_W(OP_W)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .A       (A),
    .B       (B),
    .S       (S),
    .OUT     (OUT),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Values are packed as {overflow, out}.
  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ovf=%0b out=0x%02h, expected ovf=%0b out=0x%02h",
               tag, got[8], got[7:0], exp[8], exp[7:0]);
    end
  endtask

  // Reference model, written from the operation definitions.
  function automatic logic [8:0] model(input logic [7:0] a8, input logic [7:0] b8,
                                       input logic [7:0] s8);
    int a, b, mx, r;
    mx = (1 << OP_W) - 1;
    a  = int'(a8) % (mx + 1);
    b  = int'(b8) % (mx + 1);
    case (s8)
      8'd0: begin r = a + b; return {(r > mx) ? 1'b1 : 1'b0, 8'(r)}; end
      8'd1: begin r = (a - b + 256) % 256; return {1'b0, 8'(r)}; end
      8'd2: begin r = a + 1; return {(a == mx) ? 1'b1 : 1'b0, 8'(r)}; end
      default: return 9'd0;
    endcase
  endfunction

  // Drive one operation, queue its expectation, and compare after the capturing edge.
  task automatic drive(input string tag, input logic [7:0] a8, input logic [7:0] b8,
                       input logic [7:0] s8, input logic [8:0] exp);
    logic [8:0] e;
    @(negedge CLK);
    A = a8; B = b8; S = s8;
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 9'h1FF, 9'h000);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, {OVERFLOW, OUT}, e);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ra, rb, rs;

    // Assert reset asynchronously, away from any clock edge.
    #1 RST_N = 1'b0;
    #2 check_eq("reset_async", {OVERFLOW, OUT}, 9'h000);
    repeat (2) @(posedge CLK);
    #1 check_eq("reset_hold", {OVERFLOW, OUT}, 9'h000);
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed cases with hand-derived expectations for OP_W = 3.
    drive("add_1_5",      8'h01, 8'h05, 8'h00, {1'b0, 8'd6});
    drive("add_5_6",      8'h05, 8'h06, 8'h00, {1'b1, 8'd11});
    drive("sub_4_1",      8'h04, 8'h01, 8'h01, {1'b0, 8'd3});
    drive("sub_1_5",      8'h01, 8'h05, 8'h01, {1'b0, 8'hFC});
    drive("inc_4",        8'h04, 8'h04, 8'h02, {1'b0, 8'd5});
    drive("inc_7",        8'h07, 8'h00, 8'h02, {1'b1, 8'd8});
    drive("clr_3_1",      8'h03, 8'h01, 8'h03, 9'h000);
    drive("sel_a5",       8'h05, 8'h07, 8'hA5, 9'h000);
    drive("mask_f9_0e",   8'hF9, 8'h0E, 8'h00, {1'b0, 8'd7});
    drive("add_zero",     8'h00, 8'h00, 8'h00, 9'h000);
    drive("add_max",      8'h07, 8'h07, 8'h00, {1'b1, 8'd14});
    drive("add_edge7",    8'h03, 8'h04, 8'h00, {1'b0, 8'd7});
    drive("add_edge8",    8'h04, 8'h04, 8'h00, {1'b1, 8'd8});
    drive("sub_eq",       8'h06, 8'h06, 8'h01, 9'h000);
    drive("sub_0_7",      8'h00, 8'h07, 8'h01, {1'b0, 8'hF9});
    drive("sub_mask",     8'hFF, 8'hF8, 8'h01, {1'b0, 8'd7});
    drive("inc_mask",     8'hFE, 8'h00, 8'h02, {1'b0, 8'd7});
    drive("sel_04",       8'h07, 8'h07, 8'h04, 9'h000);
    drive("sel_ff",       8'h07, 8'h07, 8'hFF, 9'h000);
    drive("sel_80",       8'h07, 8'h07, 8'h80, 9'h000);
    drive("sel_10",       8'h02, 8'h03, 8'h10, 9'h000);

    // Random operations, back to back, against the model.
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 4))
        0: rs = 8'd0;
        1: rs = 8'd1;
        2: rs = 8'd2;
        3: rs = 8'd3;
        default: rs = 8'($urandom);
      endcase
      drive("rand", ra, rb, rs, model(ra, rb, rs));
    end

    // Mid-operation reset: the loaded result must be discarded at once.
    drive("pre_reset", 8'h05, 8'h06, 8'h00, {1'b1, 8'd11});
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 check_eq("rst_mid_async", {OVERFLOW, OUT}, 9'h000);
    exp_q.delete();
    @(posedge CLK);
    #1 check_eq("rst_mid_hold1", {OVERFLOW, OUT}, 9'h000);
    A = 8'h07; B = 8'h07; S = 8'h02;
    @(posedge CLK);
    #1 check_eq("rst_mid_hold2", {OVERFLOW, OUT}, 9'h000);
    @(negedge CLK);
    A = 8'h05; B = 8'h06; S = 8'h00;
    RST_N = 1'b1;
    exp_q.push_back({1'b1, 8'd11});
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) check_eq("rst_release_queue_empty", 9'h1FF, 9'h000);
    else check_eq("rst_release", {OVERFLOW, OUT}, exp_q.pop_front());

    drive("post_reset_sub", 8'h04, 8'h01, 8'h01, {1'b0, 8'd3});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
